// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - UART transmitter handshake/line bundle with master and slave views
interface uart_tx_if #(
  parameter int NBIT_DATA_LEN = 8
);
  logic                     tx_start;
  logic [NBIT_DATA_LEN-1:0] data_in;
  logic                     tx;
  logic                     tx_busy;
  logic                     tx_done_tick;

  // Master side: the interface block that launches frames and watches status.
  modport master (
    output tx_start,
    output data_in,
    input  tx,
    input  tx_busy,
    input  tx_done_tick
  );

  // Slave side: the serializer itself.
  modport slave (
    input  tx_start,
    input  data_in,
    output tx,
    output tx_busy,
    output tx_done_tick
  );
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART frame serializer paced by an oversampling tick; `UART_TX_PARITY_EN adds an even parity bit
module uart_tx #(
  parameter int NBIT_DATA_LEN = 8,
  parameter int NUM_TICKS     = 16,
  parameter int STOP_BITS     = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      s_tick,
  uart_tx_if.slave  bus
);

  localparam int TW = (NUM_TICKS > 1) ? $clog2(NUM_TICKS) : 1;
  localparam int NW = (NBIT_DATA_LEN > 1) ? $clog2(NBIT_DATA_LEN) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(NUM_TICKS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NBIT_DATA_LEN - 1);
  localparam logic [NW-1:0] S_LAST = NW'(STOP_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [TW-1:0]            t_q, t_d;
  logic [NW-1:0]            n_q, n_d;
  logic [NBIT_DATA_LEN-1:0] shreg_q, shreg_d;
  logic                     tx_q, tx_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                     par_q, par_d;
`endif

  logic bit_end;
  assign bit_end = s_tick && (t_q == T_LAST);

  // Next-state, counter and output computation; outputs are derived from the
  // next state so the registered line changes on the same edge as the FSM.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          shreg_d = bus.data_in;
          t_d     = '0;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          // Parity comes from the accepted byte, since the shift register is consumed.
          par_d   = ^bus.data_in;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          t_d     = '0;
          n_d     = '0;
          state_d = DATA;
        end else if (s_tick) begin
          t_d = t_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          t_d     = '0;
          shreg_d = shreg_q >> 1;
          if (n_q == N_LAST) begin
            n_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            n_d = n_q + 1'b1;
          end
        end else if (s_tick) begin
          t_d = t_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          t_d     = '0;
          n_d     = '0;
          state_d = STOP;
        end else if (s_tick) begin
          t_d = t_q + 1'b1;
        end
      end
`endif
      STOP: begin
        // n counts stop bits here so the stop interval needs no wider counter.
        if (bit_end) begin
          t_d = '0;
          if (n_q == S_LAST) begin
            n_d     = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            n_d = n_q + 1'b1;
          end
        end else if (s_tick) begin
          t_d = t_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
        n_d     = '0;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase

    // Busy also covers the done cycle so a back-to-back frame shows no busy gap.
    busy_d = (state_d != IDLE) || done_d;
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

  logic clk = 1'b0;
  logic reset;
  logic s_tick;
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;
  int   div    = 1;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + 8 + P + 1;

  uart_tx_if #(.NBIT_DATA_LEN(8)) bus ();

  uart_tx #(
    .NBIT_DATA_LEN(8),
    .NUM_TICKS(16),
    .STOP_BITS(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s_tick(s_tick),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 time unit after the edge, schedule s_tick for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
    phase++;
    s_tick = ((phase % div) == 0);
  endtask

  task automatic start(input logic [7:0] d);
    bus.tx_start = 1'b1;
    bus.data_in  = d;
    s_tick       = 1'b1;
    phase        = 0;
    step();
    bus.tx_start = 1'b0;
  endtask

  // Check a whole frame cycle by cycle from the cycle after accept; ends in the done cycle.
  task automatic frame(input string name, input logic [7:0] d, input int strobe_at);
    int         bitlen;
    int         idx;
    logic       exp_bit;
    logic [7:0] rx;
    bitlen = 16 * div;
    rx     = 8'h00;
    for (int c = 0; c < NBITS * bitlen; c++) begin
      idx = c / bitlen;
      if (idx == 0)               exp_bit = 1'b0;
      else if (idx <= 8)          exp_bit = d[idx-1];
      else if (idx == NBITS - 1)  exp_bit = 1'b1;
      else                        exp_bit = ^d;
      check({name, " tx"}, 32'(bus.tx), 32'(exp_bit));
      check({name, " busy"}, 32'(bus.tx_busy), 32'd1);
      check({name, " done early"}, 32'(bus.tx_done_tick), 32'd0);
      if (idx >= 1 && idx <= 8 && (c % bitlen) == bitlen / 2) rx[idx-1] = bus.tx;
      if (c == strobe_at) begin
        bus.tx_start = 1'b1;
        bus.data_in  = 8'hFF;
      end
      step();
      bus.tx_start = 1'b0;
    end
    check({name, " done"}, 32'(bus.tx_done_tick), 32'd1);
    check({name, " stop level"}, 32'(bus.tx), 32'd1);
    check({name, " busy at done"}, 32'(bus.tx_busy), 32'd1);
    check({name, " decoded"}, 32'(rx), 32'(d));
  endtask

  initial begin
    reset        = 1'b1;
    s_tick       = 1'b0;
    bus.tx_start = 1'b0;
    bus.data_in  = 8'h00;
    step();
    step();
    check("reset tx", 32'(bus.tx), 32'd1);
    check("reset busy", 32'(bus.tx_busy), 32'd0);
    check("reset done", 32'(bus.tx_done_tick), 32'd0);
    reset = 1'b0;
    step();
    check("idle tx", 32'(bus.tx), 32'd1);
    check("idle busy", 32'(bus.tx_busy), 32'd0);

    // 0x55 frame, then back-to-back 0x0F started in the done cycle
    start(8'h55);
    frame("t1", 8'h55, -1);
    check("b2b busy in done cycle", 32'(bus.tx_busy), 32'd1);
    start(8'h0F);
    frame("t3", 8'h0F, -1);
    step();
    check("t3 done single", 32'(bus.tx_done_tick), 32'd0);
    check("t3 busy after", 32'(bus.tx_busy), 32'd0);
    check("t3 idle tx", 32'(bus.tx), 32'd1);

    // 0xA3 with a 0xFF strobe mid-frame that must be dropped
    start(8'hA3);
    frame("t2", 8'hA3, 40);
    step();
    check("t2 done single", 32'(bus.tx_done_tick), 32'd0);
    check("t2 busy after", 32'(bus.tx_busy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("t2 no queued frame", 32'(bus.tx), 32'd1);
      check("t2 stays idle", 32'(bus.tx_busy), 32'd0);
    end

    // Reset in the middle of the data bits, then a fresh frame
    start(8'hC5);
    repeat (70) step();
    check("t4 busy before reset", 32'(bus.tx_busy), 32'd1);
    reset = 1'b1;
    step();
    check("t4 reset tx", 32'(bus.tx), 32'd1);
    check("t4 reset busy", 32'(bus.tx_busy), 32'd0);
    check("t4 reset done", 32'(bus.tx_done_tick), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4 no done after reset", 32'(bus.tx_done_tick), 32'd0);
      check("t4 idle line", 32'(bus.tx), 32'd1);
    end
    start(8'h3C);
    frame("t4", 8'h3C, -1);
    step();

    // Slow tick: one s_tick every 4 clocks
    div = 4;
    start(8'h81);
    frame("t5", 8'h81, -1);
    step();
    check("t5 done single", 32'(bus.tx_done_tick), 32'd0);
    div = 1;

`ifdef UART_TX_PARITY_EN
    start(8'h07);
    frame("t6", 8'h07, -1);
    step();
    check("t6 busy after", 32'(bus.tx_busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
